// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLOSE = 2'd2
  } state_t;

  // Narrowest length field that can still hold burst_max.
  function automatic int blen_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

  // A zero-length request still moves one word; oversize requests are capped.
  function automatic int clamp_len(input int len, input int burst_max);
    if (len == 0) return 1;
    if (len > burst_max) return burst_max;
    return len;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// Round-robin picker: first eligible index at or after rr_ptr, wrapping.
module rr_priority_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  winner,
  output logic             any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest eligible wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (eligible[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end

  assign any = |eligible;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-granular round-robin arbiter sharing one FIFO write port between
// NREQ requesters; fifo_full gates every write combinationally.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE     = 32,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 16,
  parameter int BLEN_W    = blen_width(BURST_MAX)
) (
  input  logic                    write_clk,
  input  logic                    write_rst,
  input  logic                    flush,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_mask,
  input  logic [NREQ*BLEN_W-1:0]  req_len,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  input  logic                    fifo_full,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         abort,
  output logic [DSIZE-1:0]        write_data,
  output logic                    write_enable,
  output logic                    busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_reg;
  logic [NREQ-1:0]   grant_reg;
  logic [NREQ-1:0]   done_reg;
  logic [NREQ-1:0]   abort_reg;
  logic [PTR_W-1:0]  owner_reg;
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [BLEN_W-1:0] len_reg;
  logic [BLEN_W-1:0] beat_reg;

  logic [BLEN_W-1:0] len_arr  [NREQ];
  logic [DSIZE-1:0]  data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign len_arr[gi]  = req_len[gi*BLEN_W +: BLEN_W];
    assign data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
  end

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  winner;
  logic             any_eligible;
  logic [PTR_W-1:0] win_idx;

  assign eligible = req & req_mask;

  rr_priority_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_reg),
    .winner   (winner),
    .any      (any_eligible)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
    end
  end

  // flush wins over the datapath in the very cycle it is raised.
  logic burst_active;
  logic owner_drop;
  logic last_beat;
  logic [PTR_W-1:0] next_ptr;

  assign burst_active = (state_reg == BURST) && !flush;
  assign write_enable = burst_active && req_valid[owner_reg] && !fifo_full;
  assign req_ready    = grant_reg & {NREQ{burst_active && !fifo_full}};
  assign write_data   = data_arr[owner_reg];
  assign owner_drop   = !(req[owner_reg] && req_mask[owner_reg]);
  assign last_beat    = write_enable && (beat_reg == len_reg - BLEN_W'(1));
  assign next_ptr     = (owner_reg == PTR_W'(NREQ - 1)) ? '0 : owner_reg + PTR_W'(1);

  assign grant = grant_reg;
  assign done  = done_reg;
  assign abort = abort_reg;
  assign busy  = (state_reg != IDLE);

  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      done_reg   <= '0;
      abort_reg  <= '0;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      len_reg    <= '0;
      beat_reg   <= '0;
    end else begin
      done_reg  <= '0;
      abort_reg <= '0;
      if (flush) begin
        abort_reg  <= (state_reg == BURST) ? grant_reg : '0;
        state_reg  <= IDLE;
        grant_reg  <= '0;
        rr_ptr_reg <= '0;
        beat_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (any_eligible) begin
              grant_reg <= winner;
              owner_reg <= win_idx;
              len_reg   <= BLEN_W'(clamp_len(int'(len_arr[win_idx]), BURST_MAX));
              beat_reg  <= '0;
              state_reg <= BURST;
            end
          end
          BURST: begin
            if (write_enable) beat_reg <= beat_reg + BLEN_W'(1);
            // Completion and termination pulses are launched here so they
            // are visible during the CLOSE cycle.
            if (last_beat) begin
              done_reg  <= grant_reg;
              grant_reg <= '0;
              state_reg <= CLOSE;
            end else if (owner_drop) begin
              abort_reg <= grant_reg;
              grant_reg <= '0;
              state_reg <= CLOSE;
            end
          end
          CLOSE: begin
            rr_ptr_reg <= next_ptr;
            state_reg  <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
